// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that drives an up/down counter enable for a granted run length.
// Optional abort input is enabled by defining COUNT_ARBITER_ABORT_EN.
module count_arbiter #(
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
`ifdef COUNT_ARBITER_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       gnt,
  output logic             en,
  output logic             up_dn,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic [N-1:0]     count_exp
);

  // state | meaning
  // IDLE  | waiting for a request; grant issued combinationally
  // RUN   | counter enabled, remaining counts down to the last cycle
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N-1:0]     CNT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             dir_q;
  logic             prio;
  logic             owner_q;
  logic [N-1:0]     cnt;

  logic             sel;
  logic             take;
  logic [LEN_W-1:0] sel_len;
  logic             sel_dir;
  logic             abort_hit;

  always_comb begin
    sel     = (req == 2'b11) ? prio : req[1];
    take    = (state == IDLE) && (req != 2'b00) && !rst;
    sel_len = sel ? len1 : len0;
    sel_dir = sel ? dir1 : dir0;
  end

`ifdef COUNT_ARBITER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Outputs are gated by rst so they read inactive for the whole reset cycle.
  assign gnt       = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign en        = (state == RUN) && !rst;
  assign up_dn     = en && dir_q;
  assign busy      = ((state == RUN) || (state == DONE)) && !rst;
  assign done      = (state == DONE) && !rst;
  assign owner     = owner_q;
  assign count_exp = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      prio      <= 1'b0;
      owner_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner_q   <= sel;
            prio      <= ~sel;
            dir_q     <= sel_dir;
            remaining <= sel_len;
            state     <= (sel_len == LEN_ZERO) ? DONE : RUN;
          end
        end
        RUN: begin
          cnt       <= dir_q ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
          remaining <= remaining - LEN_ONE;
          if ((remaining == LEN_ONE) || abort_hit)
            state <= DONE;
        end
        DONE: begin
          remaining <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Cycle-by-cycle vector table for count_arbiter, followed by hand-written run and abort sequences.
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       dir0, dir1;
  logic [7:0] len0, len1;
  logic [1:0] gnt;
  logic       en, up_dn, busy, owner, done;
  logic [7:0] count_exp;
`ifdef COUNT_ARBITER_ABORT_EN
  logic       abort = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  count_arbiter #(.N(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .dir0(dir0), .dir1(dir1),
    .len0(len0), .len1(len1),
`ifdef COUNT_ARBITER_ABORT_EN
    .abort(abort),
`endif
    .gnt(gnt), .en(en), .up_dn(up_dn), .busy(busy), .owner(owner),
    .done(done), .count_exp(count_exp)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       dir0, dir1;
    logic [7:0] len0, len1;
    logic [1:0] gnt;
    logic       en, up_dn, busy, done, owner;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] rq, input logic d0, input logic d1,
                     input logic [7:0] l0, input logic [7:0] l1,
                     input logic [1:0] g, input logic e, input logic u, input logic b,
                     input logic dn, input logic o, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.req = rq; v.dir0 = d0; v.dir1 = d1; v.len0 = l0; v.len1 = l1;
    v.gnt = g; v.en = e; v.up_dn = u; v.busy = b; v.done = dn; v.owner = o; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
  endtask

  initial begin
    int en_cnt;
    int overlap;
    bit saw_done;

    rst = 1'b1; req = 2'b00; dir0 = 1'b0; dir1 = 1'b0; len0 = 8'd0; len1 = 8'd0;
    repeat (2) @(posedge clk);

    //   rst rq    d0 d1 l0 l1   gnt   en up bsy dn own cnt
    // single run, len 5 up
    add(1, 2'b00, 0, 0,  0, 0,  2'b00, 0, 0, 0, 0, 0, 8'd0);
    add(0, 2'b01, 0, 0,  5, 0,  2'b01, 0, 0, 0, 0, 0, 8'd0);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 1, 0, 1, 0, 0, 8'd0);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 1, 0, 1, 0, 0, 8'd1);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 1, 0, 1, 0, 0, 8'd2);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 1, 0, 1, 0, 0, 8'd3);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 1, 0, 1, 0, 0, 8'd4);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 0, 0, 1, 1, 0, 8'd5);
    add(0, 2'b00, 0, 0,  5, 0,  2'b00, 0, 0, 0, 0, 0, 8'd5);
    // wrap below zero with requester 1, down, len 3
    add(1, 2'b00, 0, 1,  0, 3,  2'b00, 0, 0, 0, 0, 0, 8'd5);
    add(0, 2'b10, 0, 1,  0, 3,  2'b10, 0, 0, 0, 0, 0, 8'd0);
    add(0, 2'b00, 0, 1,  0, 3,  2'b00, 1, 1, 1, 0, 1, 8'd0);
    add(0, 2'b00, 0, 1,  0, 3,  2'b00, 1, 1, 1, 0, 1, 8'd255);
    add(0, 2'b00, 0, 1,  0, 3,  2'b00, 1, 1, 1, 0, 1, 8'd254);
    add(0, 2'b00, 0, 1,  0, 3,  2'b00, 0, 0, 1, 1, 1, 8'd253);
    add(0, 2'b00, 0, 1,  0, 3,  2'b00, 0, 0, 0, 0, 1, 8'd253);
    // zero-length run: grant then done, no en
    add(0, 2'b01, 0, 0,  0, 0,  2'b01, 0, 0, 0, 0, 1, 8'd253);
    add(0, 2'b00, 0, 0,  0, 0,  2'b00, 0, 0, 1, 1, 0, 8'd253);
    add(0, 2'b00, 0, 0,  0, 0,  2'b00, 0, 0, 0, 0, 0, 8'd253);
    // both requesting: alternate 0,1,0,1; len changes while busy are ignored
    add(1, 2'b11, 0, 1,  2, 2,  2'b00, 0, 0, 0, 0, 0, 8'd253);
    add(0, 2'b11, 0, 1,  2, 2,  2'b01, 0, 0, 0, 0, 0, 8'd0);
    add(0, 2'b11, 0, 1,  9, 2,  2'b00, 1, 0, 1, 0, 0, 8'd0);
    add(0, 2'b11, 0, 1,  9, 2,  2'b00, 1, 0, 1, 0, 0, 8'd1);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 0, 0, 1, 1, 0, 8'd2);
    add(0, 2'b11, 0, 1,  2, 2,  2'b10, 0, 0, 0, 0, 0, 8'd2);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 1, 1, 1, 0, 1, 8'd2);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 1, 1, 1, 0, 1, 8'd1);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 0, 0, 1, 1, 1, 8'd0);
    add(0, 2'b11, 0, 1,  2, 2,  2'b01, 0, 0, 0, 0, 1, 8'd0);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 1, 0, 1, 0, 0, 8'd0);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 1, 0, 1, 0, 0, 8'd1);
    add(0, 2'b11, 0, 1,  2, 2,  2'b00, 0, 0, 1, 1, 0, 8'd2);
    add(0, 2'b11, 0, 1,  2, 2,  2'b10, 0, 0, 0, 0, 0, 8'd2);
    add(0, 2'b00, 0, 1,  2, 2,  2'b00, 1, 1, 1, 0, 1, 8'd2);
    add(0, 2'b00, 0, 1,  2, 2,  2'b00, 1, 1, 1, 0, 1, 8'd1);
    add(0, 2'b00, 0, 1,  2, 2,  2'b00, 0, 0, 1, 1, 1, 8'd0);
    add(0, 2'b00, 0, 1,  2, 2,  2'b00, 0, 0, 0, 0, 1, 8'd0);
    // reset on the 2nd en cycle of a len 10 run: no done afterwards
    add(0, 2'b01, 0, 0, 10, 0,  2'b01, 0, 0, 0, 0, 1, 8'd0);
    add(0, 2'b00, 0, 0, 10, 0,  2'b00, 1, 0, 1, 0, 0, 8'd0);
    add(1, 2'b00, 0, 0, 10, 0,  2'b00, 0, 0, 0, 0, 0, 8'd1);
    add(0, 2'b00, 0, 0, 10, 0,  2'b00, 0, 0, 0, 0, 0, 8'd0);
    add(0, 2'b00, 0, 0, 10, 0,  2'b00, 0, 0, 0, 0, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; dir0 = vecs[i].dir0; dir1 = vecs[i].dir1;
      len0 = vecs[i].len0; len1 = vecs[i].len1;
      #1;
      chk("gnt",       i, int'(gnt),       int'(vecs[i].gnt));
      chk("en",        i, int'(en),        int'(vecs[i].en));
      chk("up_dn",     i, int'(up_dn),     int'(vecs[i].up_dn));
      chk("busy",      i, int'(busy),      int'(vecs[i].busy));
      chk("done",      i, int'(done),      int'(vecs[i].done));
      chk("owner",     i, int'(owner),     int'(vecs[i].owner));
      chk("count_exp", i, int'(count_exp), int'(vecs[i].cnt));
    end

    // Requester 1 alone, len 4 up, from count 0: bounded wait for done.
    @(negedge clk);
    req = 2'b10; dir1 = 1'b0; len1 = 8'd4;
    #1;
    chk("seq_gnt", 100, int'(gnt), 2);
    en_cnt = 0; overlap = 0; saw_done = 1'b0;
    for (int c = 0; c < 20 && !saw_done; c++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      if (en) en_cnt++;
      if (en && gnt != 2'b00) overlap++;
      if (done) saw_done = 1'b1;
    end
    chk("seq_done_seen", 101, int'(saw_done), 1);
    chk("seq_en_cycles", 102, en_cnt, 4);
    chk("seq_en_gnt_overlap", 103, overlap, 0);
    chk("seq_count", 104, int'(count_exp), 4);

`ifdef COUNT_ARBITER_ABORT_EN
    // len 8 run aborted on its 3rd en cycle, starting from count 4.
    @(negedge clk);
    req = 2'b01; dir0 = 1'b0; len0 = 8'd8;
    #1;
    chk("abort_gnt", 200, int'(gnt), 1);
    en_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 2'b00;
      abort = (c == 2);
      #1;
      if (en) en_cnt++;
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_en_cycles", 201, en_cnt, 3);
    chk("abort_done", 202, int'(done), 1);
    chk("abort_en_off", 203, int'(en), 0);
    chk("abort_count", 204, int'(count_exp), 7);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_idle_busy", 205, int'(busy), 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_idle_done", 206, int'(done), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter N, default 8: width of the controlled up/down counter and of count_exp.
REQ-002 Parameter LEN_W, default 8: width of each requester's run-length field.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, 2: req[i] high = requester i has a pending run; held until gnt[i].
REQ-006 Port dir0 / dir1, input, 1 each: run direction per requester; 1 = down, 0 = up.
REQ-007 Port len0 / len1, input, LEN_W each: number of counter enable cycles requested.
REQ-008 Port gnt, output, 2: one-cycle accept pulse, at most one bit set.
REQ-009 Port en, output, 1: counter enable to the counter.
REQ-010 Port up_dn, output, 1: counter direction; 1 = decrement, 0 = increment.
REQ-011 Port busy, output, 1: high in RUN and DONE.
REQ-012 Port owner, output, 1: index of the requester currently served; holds its last value in IDLE.
REQ-013 Port done, output, 1: one-cycle pulse closing each granted run.
REQ-014 Port count_exp, output, N: expected counter value, for scoreboard comparison.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE, no req: remain in IDLE; gnt=0, en=0.
- Any req set: grant per REQ-017.
- Assert gnt[i] in that same cycle.
- Latch dir_i / len_i; set owner=i.
REQ-017 Arbitration is round-robin with priority pointer prio.
- Both req set: grant requester prio.
- One req set: grant it regardless of prio.
- After each grant to i: prio = ~i.
REQ-018 Latched len = 0: go IDLE->DONE directly; en never asserted.
- Otherwise go IDLE->RUN with remaining = len.
REQ-019 RUN: en=1, up_dn=latched dir, remaining decrements every cycle.
- remaining==1: transition to DONE.
- Grant in cycle T yields en high exactly in cycles T+1..T+len.
REQ-020 DONE: done=1, en=0 for exactly one cycle, then IDLE.
- Next gnt no earlier than the cycle after DONE.
REQ-021 req changes while busy are ignored; len/dir are sampled only at grant.
REQ-022 count_exp: +1 per en cycle with up_dn=0, -1 per en cycle with up_dn=1.
- Arithmetic modulo 2^N: 0-1 wraps to 2^N-1; 2^N-1+1 wraps to 0.
REQ-023 en and gnt are never high in the same cycle.

Reset
REQ-024 rst high at a clock edge forces state=IDLE, remaining=0, prio=0, owner=0, count_exp=0.
REQ-025 During and on release of rst: gnt=0, en=0, done=0, busy=0, up_dn=0.
REQ-026 rst asserted mid-RUN ends the run at once; no done pulse is produced for it.

Configuration
REQ-027 Macro COUNT_ARBITER_ABORT_EN defined: adds 1-bit input abort.
- abort high in RUN: en=0 from the next cycle; go to DONE.
- done pulses; count_exp reflects only the en cycles already issued.
- abort is ignored in IDLE and DONE.
REQ-028 Macro undefined: abort port absent; every run completes its full length.

Verification
REQ-029 Reset, then req=01, dir0=0, len0=5.
- gnt=01 at T; en high T+1..T+5; done at T+6.
- count_exp=5.
REQ-030 req=11 held after reset, len0=len1=2, dir1=1.
- Grant order: requester 0, then requester 1, alternating.
- count_exp returns to 0 after each pair of runs.
REQ-031 count_exp=0, requester 1 dir=1, len=3.
- count_exp: 255, 254, 253 (N=8).
- Wrap-around verified.
REQ-032 len0=0 granted.
- gnt, then done in the next cycle.
- No en; count_exp unchanged.
REQ-033 rst asserted on the 2nd en cycle of a len=10 run.
- Next cycle: en=0, busy=0, count_exp=0, no done pulse.
REQ-034 With COUNT_ARBITER_ABORT_EN, len=8, abort on the 3rd en cycle.
- Exactly 3 en cycles; done next cycle; count_exp=3.
